// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and divider helper for the UART receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_WAIT_IDLE
  } state_e;

  // Clocks per oversampling tick; users reject a result below 1 at elaboration.
  function automatic int calc_div(input int clk_hz, input int bps, input int ovs);
    return clk_hz / (bps * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, re-phased by restart.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK = 100_000_000,
  parameter int BPS = 9600,
  parameter int OVS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int DIV = calc_div(CLK, BPS, OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: CLK/(BPS*OVS) must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(DIV - 1));
  assign tick = enable && !restart && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || !enable || wrap) cnt_d = '0;
    else                            cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with majority-vote bit sampling, parity/frame checks
// and a single-entry output register with valid/ready handshake and overrun flag.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLK       = 100_000_000,
  parameter int BPS       = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int OVS       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OVS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_ext: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_ext: STOP_BITS must be 1 or 2");
  end
  if (OVS < 8 || (OVS % 2) != 0) begin : g_bad_ovs
    $error("uart_rx_ext: OVS must be even and at least 8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_ext: PARITY must be 0, 1 or 2");
  end

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  state_e               state_q, state_d;
  logic [SW-1:0]        smp_q, smp_d;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic tick, start_edge, vote_pt, bit_end, voted, done;
  logic frame_perr, frame_ferr;

  assign start_edge = (state_q == ST_IDLE) && rx_prev_q && !rx_s2_q;
  assign vote_pt    = tick && (smp_q == SW'(OVS/2 + 1));
  assign bit_end    = tick && (smp_q == SW'(OVS - 1));
  assign voted      = maj3(vote_q[1], vote_q[0], rx_s2_q);

  uart_baud_tick #(
    .CLK (CLK),
    .BPS (BPS),
    .OVS (OVS)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (start_edge),
    .enable  (state_q != ST_IDLE),
    .tick    (tick)
  );

  // Tick position within the current bit and the two early vote samples.
  always_comb begin
    smp_d  = smp_q;
    vote_d = vote_q;
    if (start_edge)   smp_d = '0;
    else if (bit_end) smp_d = '0;
    else if (tick)    smp_d = smp_q + 1'b1;
    if (tick && (smp_q == SW'(OVS/2 - 1) || smp_q == SW'(OVS/2)))
      vote_d = {vote_q[0], rx_s2_q};
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_START;
          bit_d   = '0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (vote_pt && voted) state_d = ST_IDLE;
        else if (bit_end)     state_d = ST_DATA;
      end
      ST_DATA: begin
        if (vote_pt) shreg_d = {voted, shreg_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (vote_pt) par_d = voted;
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // The frame completes at the last stop bit's vote so back-to-back
        // start edges are not missed.
        if (vote_pt) begin
          if (!voted) ferr_d = 1'b1;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            done    = 1'b1;
            state_d = rx_s2_q ? ST_IDLE : ST_WAIT_IDLE;
          end
        end else if (bit_end) begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_ferr = ferr_q | !voted;
  assign frame_perr = (PARITY == PAR_NONE) ? 1'b0
                    : ((^shreg_q) ^ par_q ^ (PARITY == PAR_ODD));

  // Single-entry output holding register.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (done) begin
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_valid_d   = 1'b1;
        rx_data_d    = shreg_q;
        parity_err_d = frame_perr;
        frame_err_d  = frame_ferr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= ST_IDLE;
      smp_q        <= '0;
      bit_q        <= '0;
      vote_q       <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      state_q      <= state_d;
      smp_q        <= smp_d;
      bit_q        <= bit_d;
      vote_q       <= vote_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: three instances (8N1, 8E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_ext;

  localparam int TCLK = 1_600_000;
  localparam int TBPS = 100_000;
  localparam int TOVS = 8;
  localparam int BITC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_l     [3];
  logic       rx_ready [3];
  logic [7:0] rx_data  [3];
  logic       rx_valid [3];
  logic       parity_err [3];
  logic       frame_err  [3];
  logic       overrun  [3];
  logic       busy     [3];

  int n_chk  = 0;
  int n_pass = 0;

  int         nwords [3];
  int         nvalid [3];
  int         novr   [3];
  logic [7:0] last_data [3];
  logic       last_pe [3];
  logic       last_fe [3];

  always #5 clk = ~clk;

  uart_rx_ext #(.CLK(TCLK), .BPS(TBPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVS(TOVS)) u_n1 (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .parity_err(parity_err[0]), .frame_err(frame_err[0]),
    .overrun(overrun[0]), .busy(busy[0]));

  uart_rx_ext #(.CLK(TCLK), .BPS(TBPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVS(TOVS)) u_e1 (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .parity_err(parity_err[1]), .frame_err(frame_err[1]),
    .overrun(overrun[1]), .busy(busy[1]));

  uart_rx_ext #(.CLK(TCLK), .BPS(TBPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVS(TOVS)) u_n2 (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
    .rx_ready(rx_ready[2]), .parity_err(parity_err[2]), .frame_err(frame_err[2]),
    .overrun(overrun[2]), .busy(busy[2]));

  initial begin
    for (int d = 0; d < 3; d++) begin
      nwords[d] = 0; nvalid[d] = 0; novr[d] = 0;
      last_data[d] = '0; last_pe[d] = 1'b0; last_fe[d] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rx_valid[d]) nvalid[d]++;
      if (overrun[d]) novr[d]++;
      if (rx_valid[d] && rx_ready[d]) begin
        nwords[d]++;
        last_data[d] = rx_data[d];
        last_pe[d]   = parity_err[d];
        last_fe[d]   = frame_err[d];
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the final stop bit can be forced low.
  task automatic send_frame(input int d, input logic [7:0] data, input logic par_bit,
                            input logic last_stop_lo);
    int nstop;
    nstop = (d == 2) ? 2 : 1;
    rx_l[d] = 1'b0; cyc(BITC);
    for (int i = 0; i < 8; i++) begin
      rx_l[d] = data[i]; cyc(BITC);
    end
    if (d == 1) begin
      rx_l[d] = par_bit; cyc(BITC);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_l[d] = (i == nstop - 1) ? !last_stop_lo : 1'b1; cyc(BITC);
    end
    rx_l[d] = 1'b1;
  endtask

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_lo;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    int w0, v0, o0;

    vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h07, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0};
    vecs[2] = '{1, 8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
    vecs[3] = '{2, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
    vecs[4] = '{0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h03, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0};
    vecs[8] = '{2, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0};

    for (int d = 0; d < 3; d++) begin
      rx_l[d] = 1'b1;
      rx_ready[d] = 1'b1;
    end
    rst = 1'b1;
    cyc(3);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_valid[%0d]", d), rx_valid[d], 0);
      chk($sformatf("reset_busy[%0d]", d), busy[d], 0);
      chk($sformatf("reset_data[%0d]", d), rx_data[d], 0);
      chk($sformatf("reset_overrun[%0d]", d), overrun[d], 0);
    end
    rst = 1'b0;
    cyc(4);

    for (int i = 0; i < 9; i++) begin
      w0 = nwords[vecs[i].dut];
      v0 = nvalid[vecs[i].dut];
      send_frame(vecs[i].dut, vecs[i].data, vecs[i].par_bit, vecs[i].stop_lo);
      cyc(2 * BITC);
      chk($sformatf("vec%0d_words", i), nwords[vecs[i].dut] - w0, 1);
      chk($sformatf("vec%0d_data", i), last_data[vecs[i].dut], vecs[i].exp_data);
      chk($sformatf("vec%0d_parity_err", i), last_pe[vecs[i].dut], vecs[i].exp_pe);
      chk($sformatf("vec%0d_frame_err", i), last_fe[vecs[i].dut], vecs[i].exp_fe);
      if (i == 0) chk("vec0_valid_cycles", nvalid[0] - v0, 1);
    end

    // False start: line low for three ticks only.
    w0 = nwords[0];
    v0 = nvalid[0];
    rx_l[0] = 1'b0;
    cyc(6);
    rx_l[0] = 1'b1;
    chk("false_start_busy_hi", busy[0], 1);
    cyc(2 * BITC);
    chk("false_start_busy_lo", busy[0], 0);
    chk("false_start_words", nwords[0] - w0, 0);
    chk("false_start_valid", nvalid[0] - v0, 0);

    // Break: line low for 20 bit times on 8N2.
    w0 = nwords[2];
    rx_l[2] = 1'b0;
    cyc(20 * BITC);
    chk("break_words", nwords[2] - w0, 1);
    chk("break_data", last_data[2], 8'h00);
    chk("break_frame_err", last_fe[2], 1);
    chk("break_busy_wait", busy[2], 1);
    rx_l[2] = 1'b1;
    cyc(3 * BITC);
    chk("break_words_after", nwords[2] - w0, 1);
    chk("break_busy_idle", busy[2], 0);

    // Overrun, then completion coinciding with acceptance.
    rx_ready[0] = 1'b0;
    o0 = novr[0];
    send_frame(0, 8'h11, 1'b0, 1'b0);
    cyc(BITC);
    chk("ovr_first_valid", rx_valid[0], 1);
    chk("ovr_first_data", rx_data[0], 8'h11);
    send_frame(0, 8'h22, 1'b0, 1'b0);
    cyc(BITC);
    chk("ovr_pulse_count", novr[0] - o0, 1);
    chk("ovr_data_kept", rx_data[0], 8'h11);
    chk("ovr_valid_kept", rx_valid[0], 1);
    w0 = nwords[0];
    fork
      send_frame(0, 8'h22, 1'b0, 1'b0);
      begin
        cyc(158);
        rx_ready[0] = 1'b1;
        cyc(1);
        rx_ready[0] = 1'b0;
      end
    join
    cyc(BITC);
    chk("coincide_accepted_old", last_data[0], 8'h11);
    chk("coincide_words", nwords[0] - w0, 1);
    chk("coincide_no_overrun", novr[0] - o0, 1);
    chk("coincide_new_data", rx_data[0], 8'h22);
    chk("coincide_new_valid", rx_valid[0], 1);
    rx_ready[0] = 1'b1;
    cyc(2);
    chk("coincide_drain_data", last_data[0], 8'h22);
    chk("coincide_drain_valid", rx_valid[0], 0);

    // Reset in the middle of a data bit, with a word held on 8E1.
    rx_ready[1] = 1'b0;
    send_frame(1, 8'h07, 1'b0, 1'b0);
    cyc(BITC);
    rx_l[0] = 1'b0; cyc(BITC);
    rx_l[0] = 1'b1; cyc(BITC);
    rx_l[0] = 1'b0; cyc(BITC / 2);
    chk("rst_pre_busy", busy[0], 1);
    chk("rst_pre_held", rx_valid[1], 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_valid", rx_valid[1], 0);
    chk("rst_data", rx_data[1], 0);
    chk("rst_parity_err", parity_err[1], 0);
    rx_l[0] = 1'b1;
    cyc(2);
    rst = 1'b0;
    rx_ready[1] = 1'b1;
    cyc(2 * BITC);
    w0 = nwords[0];
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    cyc(2 * BITC);
    chk("post_rst_words", nwords[0] - w0, 1);
    chk("post_rst_data", last_data[0], 8'h3C);
    chk("post_rst_frame_err", last_fe[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
